alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Command front-end for alu_4bit. It buffers incoming ALU commands in a small FIFO and drives registered a/b/op into the combinational ALU. It captures result/carry one cycle later and returns them on a valid/ready response channel. It also supports chained operations, where operand A is taken from the previous result.

Parameters:
DEPTH, 4, command FIFO entries; power of two, minimum 2.
W, 4, operand/result width; fixed to 4 to match alu_4bit.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  W  operand A
cmd_b  input  W  operand B
cmd_op  input  3  ALU opcode
cmd_chain  input  1  1 = use accumulator in place of cmd_a
alu_a  output  W  registered operand A to ALU
alu_b  output  W  registered operand B to ALU
alu_op  output  3  registered opcode to ALU
alu_result  input  W  ALU result (combinational from alu_a/b/op)
alu_carry  input  1  ALU carry
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  W  captured result
rsp_carry  output  1  captured carry
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset: on a clk edge with rst_n=0, clear the following:
  - FIFO pointers and count.
  - State to IDLE.
  - alu_a, alu_b, alu_op, rsp_result, rsp_carry and accumulator to 0.
  - rsp_valid to 0.
- cmd_ready = rst_n && (count != DEPTH). It is 0 while rst_n is low.
- Push occurs on cmd_valid && cmd_ready. The FIFO stores {a, b, op, chain}.
- No bypass: a pop in the same cycle does not raise cmd_ready when the FIFO is full.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and load the alu regs, then go to ISSUE. Otherwise stay.
  - ISSUE: the ALU inputs are stable this cycle. Capture rsp_result <= alu_result, rsp_carry <= alu_carry, acc <= alu_result and rsp_valid <= 1, then go to RESP.
  - RESP: hold the rsp_* outputs stable while rsp_valid && !rsp_ready. On rsp_ready:
    - clear rsp_valid;
    - if the FIFO is non-empty, pop and load, then go to ISSUE;
    - otherwise go to IDLE.
- Load rule: alu_a = chain ? acc : a. alu_b = b and alu_op = op. The alu regs hold their values until the next load.
- Latency: a command pushed at edge N into an empty FIFO with the sequencer in IDLE:
  - loads the alu regs at edge N+1;
  - raises rsp_valid after edge N+2.
- Throughput: with rsp_ready held high, one response every 2 cycles.
- The accumulator updates only in ISSUE. A chained command uses the result of the immediately preceding completed command, or 0 after reset.
- Responses are delivered in command order. No command is dropped or duplicated.
- Reset mid-operation discards the in-flight command and all queued commands. No response is produced for them.
- The arithmetic is entirely in alu_4bit. The sequencer does no width extension; carry passes through unmodified.

Test Plan:
1. Single add: push a=0011, b=0001, op=000, chain=0 at edge N, rsp_ready=1 -> rsp_valid high after edge N+2; rsp_result=0100, rsp_carry=0; alu_a=0011, alu_b=0001, alu_op=000 held afterwards.
2. Subtract then chain: push (0011, 0001, op=001), then (chain=1, b=0001, op=000) -> responses 0010, then 0011; second alu_a=0010.
3. Carry out: push 1111 + 0001, op=000 -> rsp_result=0000, rsp_carry=1; following chained add with b=0010 -> 0010.
4. Full and ordering: rsp_ready=0, cmd_valid held with 6 distinct adds -> exactly DEPTH+1=5 accepted and cmd_ready stays 0; then rsp_ready=1 -> the 5 results arrive in push order, one per 2 cycles, and busy falls after the last handshake.
5. Backpressure: hold rsp_ready=0 for 10 cycles while a response is valid -> rsp_valid, rsp_result and rsp_carry unchanged throughout; a single handshake occurs on release.
6. Reset mid-op: 3 commands queued and one in RESP; pull rst_n low for 1 cycle -> all outputs 0, busy=0, cmd_ready=1 after release, no stale responses; a chained add with b=0101 then returns 0101.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command front-end for a combinational 4-bit ALU: queues commands, drives registered
// operands, captures the result one cycle later and returns it on a valid/ready channel.
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head as soon as one is queued
// ISSUE | ALU inputs stable; capture result/carry into rsp regs and accumulator
// RESP  | response held until rsp_ready; may pop the next command on the handshake
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_chain,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    input  logic         alu_carry,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 * W + 4;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state, state_next;
    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [W-1:0]   acc;
    logic           fifo_empty;
    logic           push, pop, capture, rsp_clear;
    logic [W-1:0]   head_a, head_b;
    logic [2:0]     head_op;
    logic           head_chain;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = rst_n && (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign {head_a, head_b, head_op, head_chain} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        rsp_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage is not reset; only pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_chain};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_valid  <= 1'b0;
            acc        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                alu_a  <= head_chain ? acc : head_a;
                alu_b  <= head_b;
                alu_op <= head_op;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (capture) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                acc        <= alu_result;
                rsp_valid  <= 1'b1;
            end else if (rsp_clear) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a stand-in ALU, a push-time reference queue checked on
// every handshake, and directed scenarios with literal expectations.
module tb_alu_op_sequencer;
    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic         clk = 1'b0;
    logic         rst_n, cmd_valid, cmd_ready, cmd_chain;
    logic [W-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]   cmd_op, alu_op;
    logic         alu_carry, rsp_valid, rsp_ready, rsp_carry, busy;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy)
    );

    // Stand-in for alu_4bit: {carry, result}; subtract reports borrow as carry.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[3], a[2:0], 1'b0};
            default: return {a[0], 1'b0, a[3:1]};
        endcase
    endfunction

    always_comb {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_op);

    typedef struct {
        logic [3:0] res;
        logic       c;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } exp_t;

    exp_t       expq[$];
    exp_t       e;
    logic [3:0] model_acc = '0;
    logic [4:0] r;
    logic [3:0] a_eff;
    int         n_pass = 0, n_total = 0;
    int         cyc = 0, hs_cnt = 0;
    int         hs_cyc[$];
    int         res_log[$], c_log[$], a_log[$];
    logic       pv = 1'b0, pr = 1'b0, prst = 1'b0, pc = 1'b0;
    logic [3:0] pres = '0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            model_acc = '0;
        end else begin
            if (pv && !pr && prst) begin
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_result", int'(rsp_result), int'(pres));
                chk("hold_carry", int'(rsp_carry), int'(pc));
            end
            if (rsp_valid && expq.size() == 0) begin
                chk("stale_rsp", int'(rsp_valid), 0);
            end else if (rsp_valid && rsp_ready) begin
                e = expq.pop_front();
                chk("rsp_result", int'(rsp_result), int'(e.res));
                chk("rsp_carry", int'(rsp_carry), int'(e.c));
                chk("alu_a", int'(alu_a), int'(e.a));
                chk("alu_b", int'(alu_b), int'(e.b));
                chk("alu_op", int'(alu_op), int'(e.op));
                hs_cnt++;
                hs_cyc.push_back(cyc);
                res_log.push_back(int'(rsp_result));
                c_log.push_back(int'(rsp_carry));
                a_log.push_back(int'(alu_a));
            end
            if (cmd_valid && cmd_ready) begin
                a_eff = cmd_chain ? model_acc : cmd_a;
                r = alu_f(a_eff, cmd_b, cmd_op);
                model_acc = r[3:0];
                expq.push_back('{res: r[3:0], c: r[4], a: a_eff, b: cmd_b, op: cmd_op});
            end
        end
        pv = rsp_valid; pr = rsp_ready; prst = rst_n; pres = rsp_result; pc = rsp_carry;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic ch);
        int k;
        sync();
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; cmd_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("push_timeout", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_cnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (hs_cnt < target) chk("hs_timeout", hs_cnt, target);
    endtask

    initial begin
        int base, accepted, k;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_chain = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_ready_rel", int'(cmd_ready), 1);

        // single add with latency
        sync();
        rsp_ready = 1'b1;
        base = hs_cnt;
        push(4'b0011, 4'b0001, 3'b000, 1'b0);
        @(negedge clk);
        chk("t1_valid_n", int'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_load_a", int'(alu_a), 3);
        chk("t1_load_b", int'(alu_b), 1);
        chk("t1_valid_n1", int'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_valid_n2", int'(rsp_valid), 1);
        chk("t1_result", int'(rsp_result), 4);
        chk("t1_carry", int'(rsp_carry), 0);
        repeat (3) @(negedge clk);
        chk("t1_hold_a", int'(alu_a), 3);
        chk("t1_hold_b", int'(alu_b), 1);
        chk("t1_hold_op", int'(alu_op), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_hs", hs_cnt, base + 1);

        // subtract then chain
        base = hs_cnt;
        push(4'b0011, 4'b0001, 3'b001, 1'b0);
        push(4'b1010, 4'b0001, 3'b000, 1'b1);
        wait_hs(base + 2);
        if (hs_cnt >= base + 2) begin
            chk("t2_sub", res_log[base], 2);
            chk("t2_chain", res_log[base + 1], 3);
            chk("t2_chain_a", a_log[base + 1], 2);
        end

        // carry out then chain
        base = hs_cnt;
        push(4'b1111, 4'b0001, 3'b000, 1'b0);
        push(4'b0111, 4'b0010, 3'b000, 1'b1);
        wait_hs(base + 2);
        if (hs_cnt >= base + 2) begin
            chk("t3_result", res_log[base], 0);
            chk("t3_carry", c_log[base], 1);
            chk("t3_chain", res_log[base + 1], 2);
        end

        // fill with response stalled, then drain
        sync();
        rsp_ready = 1'b0;
        repeat (2) sync();
        base = hs_cnt;
        accepted = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_a = 4'(2 * i); cmd_b = 4'd1; cmd_op = 3'd0; cmd_chain = 1'b0;
            k = 0;
            @(negedge clk);
            while (!cmd_ready && k < 8) begin
                @(negedge clk);
                k++;
            end
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                accepted++;
            end
        end
        chk("t4_accepted", accepted, DEPTH + 1);
        @(negedge clk);
        chk("t4_full_ready", int'(cmd_ready), 0);
        chk("t4_busy", int'(busy), 1);
        sync();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_hs(base + 5);
        @(negedge clk);
        chk("t4_busy_end", int'(busy), 0);
        if (hs_cnt >= base + 5) begin
            for (int i = 0; i < 5; i++) chk("t4_order", res_log[base + i], 2 * i + 1);
            for (int i = 1; i < 5; i++) chk("t4_rate", hs_cyc[base + i] - hs_cyc[base + i - 1], 2);
        end

        // backpressure
        sync();
        rsp_ready = 1'b0;
        base = hs_cnt;
        push(4'b0110, 4'b0011, 3'b100, 1'b0);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_valid", int'(rsp_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", int'(rsp_valid), 1);
            chk("t5_hold_result", int'(rsp_result), 5);
            chk("t5_hold_carry", int'(rsp_carry), 0);
        end
        sync();
        rsp_ready = 1'b1;
        sync();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t5_released", int'(rsp_valid), 0);
        chk("t5_single_hs", hs_cnt, base + 1);

        // reset mid-operation
        push(4'd1, 4'd1, 3'd0, 1'b0);
        push(4'd2, 4'd2, 3'd0, 1'b0);
        push(4'd3, 4'd3, 3'd0, 1'b0);
        push(4'd4, 4'd4, 3'd0, 1'b0);
        base = hs_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_ready_in_rst", int'(cmd_ready), 0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_alu_a", int'(alu_a), 0);
        chk("t6_alu_b", int'(alu_b), 0);
        chk("t6_alu_op", int'(alu_op), 0);
        chk("t6_rsp_valid", int'(rsp_valid), 0);
        chk("t6_rsp_result", int'(rsp_result), 0);
        chk("t6_rsp_carry", int'(rsp_carry), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_cmd_ready", int'(cmd_ready), 1);
        sync();
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_no_stale", hs_cnt, base);
        push(4'b1001, 4'b0101, 3'b000, 1'b1);
        wait_hs(base + 1);
        if (hs_cnt >= base + 1) chk("t6_chain_after_rst", res_log[base], 5);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
